// File: rtl/serial_parity_checker.sv
// serial_parity_checker
// Receive side of the odd-parity serial link. A frame is DATA_W data bits
// (MSB first) followed by one parity bit. The XOR of all DATA_W+1 bits must
// be 1. Each completed frame is presented as a word plus an error flag, and
// saturating frame/error counters are kept for status readout.
module serial_parity_checker #(
    parameter int DATA_W = 3,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              in_bit,
    input  logic              clr_cnt,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_err,
    output logic [CNT_W-1:0]  frame_cnt,
    output logic [CNT_W-1:0]  err_cnt,
    output logic              busy
);

    // idx counts 0..DATA_W, so it needs enough bits to hold DATA_W itself
    localparam int IDX_W = $clog2(DATA_W + 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W);

    // Frame assembly state: bit index, shift register, running parity
    logic [IDX_W-1:0]  idx_p0;
    logic [DATA_W-1:0] sh_p0;
    logic              acc_p0;

    // Output stage: completion pulse travelling with the recovered word
    logic              vld_p1;
    logic [DATA_W-1:0] data_p1;
    logic              err_p1;
    logic              busy_p1;
    logic [CNT_W-1:0]  frame_cnt_p1;
    logic [CNT_W-1:0]  err_cnt_p1;

    // Combinational decode of the current input against the frame position
    logic              last_bit;
    logic              frame_done;
    logic              par_err;
    logic [IDX_W-1:0]  idx_nxt;

    // Shift a new bit into the LSB; written as a shift so DATA_W = 1 still works
    function automatic logic [DATA_W-1:0] shift_in(
        input logic [DATA_W-1:0] s,
        input logic              b
    );
        return (s << 1) | DATA_W'(b);
    endfunction

    // Counter increment that sticks at all-ones instead of wrapping
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
    endfunction

    // Decode: is this the parity bit, does the frame fail odd parity, next index
    always_comb begin
        last_bit   = (idx_p0 == IDX_LAST);
        frame_done = in_valid && last_bit;
        par_err    = ~(acc_p0 ^ in_bit);
        idx_nxt    = idx_p0;
        if (in_valid) begin
            idx_nxt = last_bit ? '0 : idx_p0 + IDX_W'(1);
        end
    end

    // ---- stage p0: frame assembly / stage p1: completed-frame outputs ----
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_p0  <= '0;
            sh_p0   <= '0;
            acc_p0  <= 1'b0;
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            err_p1  <= 1'b0;
            busy_p1 <= 1'b0;
        end else begin
            vld_p1  <= frame_done;
            idx_p0  <= idx_nxt;
            busy_p1 <= (idx_nxt != '0);
            if (in_valid) begin
                if (last_bit) begin
                    data_p1 <= sh_p0;
                    err_p1  <= par_err;
                    acc_p0  <= 1'b0;
                end else begin
                    sh_p0  <= shift_in(sh_p0, in_bit);
                    acc_p0 <= acc_p0 ^ in_bit;
                end
            end
        end
    end

    // Status counters; a clear request overrides a same-cycle completion
    always_ff @(posedge clk) begin
        if (rst || clr_cnt) begin
            frame_cnt_p1 <= '0;
            err_cnt_p1   <= '0;
        end else if (frame_done) begin
            frame_cnt_p1 <= sat_inc(frame_cnt_p1);
            if (par_err) begin
                err_cnt_p1 <= sat_inc(err_cnt_p1);
            end
        end
    end

    assign out_valid = vld_p1;
    assign out_data  = data_p1;
    assign out_err   = err_p1;
    assign busy      = busy_p1;
    assign frame_cnt = frame_cnt_p1;
    assign err_cnt   = err_cnt_p1;

endmodule

// File: tb/tb_serial_parity_checker.sv
// Bench for serial_parity_checker: a 3-bit instance driven through a
// scoreboard, plus an 8-bit instance for the wide-word case.
module tb_serial_parity_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_bit = 1'b0;
    logic       clr_cnt = 1'b0;
    logic       out_valid;
    logic [2:0] out_data;
    logic       out_err;
    logic [7:0] frame_cnt;
    logic [7:0] err_cnt;
    logic       busy;

    logic       in8_valid = 1'b0;
    logic       in8_bit = 1'b0;
    logic       clr8 = 1'b0;
    logic       out8_valid;
    logic [7:0] out8_data;
    logic       out8_err;
    logic [7:0] frame8_cnt;
    logic [7:0] err8_cnt;
    logic       busy8;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [2:0] data;
        logic       err;
        logic [7:0] fc;
        logic [7:0] ec;
    } exp_t;

    typedef struct {
        logic [2:0] word;
        logic       par;
        logic       exp_err;
    } vec_t;

    exp_t q[$];
    int   m_fc = 0;
    int   m_ec = 0;

    always #5 clk = ~clk;

    serial_parity_checker #(.DATA_W(3), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
        .clr_cnt(clr_cnt), .out_valid(out_valid), .out_data(out_data),
        .out_err(out_err), .frame_cnt(frame_cnt), .err_cnt(err_cnt),
        .busy(busy)
    );

    serial_parity_checker #(.DATA_W(8), .CNT_W(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in8_valid), .in_bit(in8_bit),
        .clr_cnt(clr8), .out_valid(out8_valid), .out_data(out8_data),
        .out_err(out8_err), .frame_cnt(frame8_cnt), .err_cnt(err8_cnt),
        .busy(busy8)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every out_valid pulse must match the oldest expected frame
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL spurious_valid: got out_valid=1 expected no frame");
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("sb_data", 32'(out_data), 32'(e.data));
                chk("sb_err", 32'(out_err), 32'(e.err));
                chk("sb_frame_cnt", 32'(frame_cnt), 32'(e.fc));
                chk("sb_err_cnt", 32'(err_cnt), 32'(e.ec));
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_fc = 0;
        m_ec = 0;
    endtask

    // One serial bit, then 'gap' idle cycles with busy checked during the gap
    task automatic send_bit(input logic b, input int gap, input logic clr, input logic exp_busy);
        in_valid = 1'b1;
        in_bit   = b;
        clr_cnt  = clr;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        clr_cnt  = 1'b0;
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            chk("busy_gap", 32'(busy), 32'(exp_busy));
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [2:0] w, input logic p, input int gap, input logic clr);
        exp_t e;
        logic err;
        for (int i = 2; i >= 0; i--) send_bit(w[i], gap, 1'b0, 1'b1);
        err = ~(w[2] ^ w[1] ^ w[0] ^ p);
        if (clr) begin
            m_fc = 0;
            m_ec = 0;
        end else begin
            if (m_fc < 255) m_fc++;
            if (err && m_ec < 255) m_ec++;
        end
        e.data = w;
        e.err  = err;
        e.fc   = 8'(m_fc);
        e.ec   = 8'(m_ec);
        q.push_back(e);
        send_bit(p, gap, clr, 1'b0);
    endtask

    task automatic drain(input string name);
        repeat (2) @(posedge clk);
        #1;
        chk(name, 32'(q.size()), 32'd0);
        q.delete();
    endtask

    task automatic send8(input logic [7:0] w, input logic p);
        for (int i = 7; i >= 0; i--) begin
            in8_valid = 1'b1;
            in8_bit   = w[i];
            @(posedge clk);
            #1;
        end
        in8_bit = p;
        @(posedge clk);
        #1;
        in8_valid = 1'b0;
        @(negedge clk);
    endtask

    vec_t tbl[9];

    initial begin
        for (int i = 0; i < 8; i++) begin
            logic [2:0] w;
            w = 3'(i);
            tbl[i].word    = w;
            tbl[i].par     = ~(w[2] ^ w[1] ^ w[0]);
            tbl[i].exp_err = 1'b0;
        end
        tbl[8].word = 3'b000; tbl[8].par = 1'b0; tbl[8].exp_err = 1'b1;

        // Reset state
        do_reset();
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_err", 32'(out_err), 32'd0);
        chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);

        // Basic frame 1,0,1 + parity 1
        send_frame(3'b101, 1'b1, 0, 1'b0);
        drain("basic_drain");
        chk("hold_data", 32'(out_data), 32'h5);

        // All eight good words, then one bad word, from the table
        do_reset();
        for (int i = 0; i < 9; i++) begin
            send_frame(tbl[i].word, tbl[i].par, 0, 1'b0);
            @(negedge clk);
            chk("tbl_err", 32'(out_err), 32'(tbl[i].exp_err));
            chk("tbl_data", 32'(out_data), 32'(tbl[i].word));
            @(posedge clk);
            #1;
        end
        drain("tbl_drain");
        chk("tbl_frame_cnt", 32'(frame_cnt), 32'd9);
        chk("tbl_err_cnt", 32'(err_cnt), 32'd1);

        // Frame with three idle cycles between every bit
        do_reset();
        send_frame(3'b110, 1'b1, 3, 1'b0);
        drain("gap_drain");
        chk("gap_data", 32'(out_data), 32'h6);
        chk("gap_err", 32'(out_err), 32'd0);

        // Partial frame discarded by reset
        do_reset();
        send_bit(1'b1, 0, 1'b0, 1'b1);
        send_bit(1'b1, 0, 1'b0, 1'b1);
        @(negedge clk);
        chk("partial_busy", 32'(busy), 32'd1);
        do_reset();
        @(negedge clk);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        send_frame(3'b011, 1'b1, 0, 1'b0);
        drain("partial_drain");
        chk("partial_frame_cnt", 32'(frame_cnt), 32'd1);

        // 300 back-to-back error frames saturate both counters
        do_reset();
        for (int i = 0; i < 300; i++) send_frame(3'b000, 1'b0, 0, 1'b0);
        drain("sat_drain");
        chk("sat_frame_cnt", 32'(frame_cnt), 32'd255);
        chk("sat_err_cnt", 32'(err_cnt), 32'd255);

        // Clear coincident with completion: counters zero, pulse still present
        send_frame(3'b000, 1'b0, 0, 1'b1);
        drain("clr_drain");
        chk("clr_frame_cnt", 32'(frame_cnt), 32'd0);
        chk("clr_err_cnt", 32'(err_cnt), 32'd0);
        chk("clr_keeps_err", 32'(out_err), 32'd1);
        send_frame(3'b100, 1'b0, 0, 1'b0);
        drain("post_clr_drain");

        // Eight-bit instance
        send8(8'hA5, 1'b1);
        chk("w8_valid", 32'(out8_valid), 32'd1);
        chk("w8_data", 32'(out8_data), 32'hA5);
        chk("w8_err", 32'(out8_err), 32'd0);
        send8(8'hA5, 1'b0);
        chk("w8_bad_data", 32'(out8_data), 32'hA5);
        chk("w8_bad_err", 32'(out8_err), 32'd1);
        chk("w8_err_cnt", 32'(err8_cnt), 32'd1);
        @(negedge clk);
        chk("w8_pulse_one_cycle", 32'(out8_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
